// File: rtl/div8b_if.sv
// Handshake and operand/result bundle for the div8b sequential divider.
// The master issues start with operands; the slave returns results with a done pulse.
interface div8b_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/div8b.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Optional DIV8B_ZERO_TRAP_EN finishes divide-by-zero after one cycle and raises div_zero.
module div8b (
    input  logic    clk,
    input  logic    rst,
    div8b_if.slave  bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n;
    logic [3:0] dreg, dreg_n;
    logic [3:0] r, r_n;
    logic [4:0] rshift;
    logic       qbit;
    logic [2:0] cnt, cnt_n;
    logic [7:0] quot, quot_n;
    logic [3:0] rem, rem_n;
    logic       done_r, done_n;
`ifdef DIV8B_ZERO_TRAP_EN
    logic       dz, dz_n;
`endif

    // The dividend register doubles as the quotient register: each step shifts the
    // next dividend MSB out the top and the new quotient bit in at the bottom.
    // Only R[3:0] is stored; R[4] exists only transiently before the compare.
    always_comb begin
        rshift  = {r, shreg[7]};
        qbit    = (rshift >= {1'b0, dreg});
        state_n = state;
        shreg_n = shreg;
        dreg_n  = dreg;
        r_n     = r;
        cnt_n   = cnt;
        quot_n  = quot;
        rem_n   = rem;
        done_n  = 1'b0;
`ifdef DIV8B_ZERO_TRAP_EN
        dz_n    = dz;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_n = bus.dividend;
                    dreg_n  = bus.divisor;
                    r_n     = 4'd0;
                    cnt_n   = 3'd0;
                    state_n = CALC;
                end
            end
            CALC: begin
                r_n     = qbit ? (rshift[3:0] - dreg) : rshift[3:0];
                shreg_n = {shreg[6:0], qbit};
                cnt_n   = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    quot_n  = {shreg[6:0], qbit};
                    rem_n   = r_n;
                    done_n  = 1'b1;
                    state_n = IDLE;
`ifdef DIV8B_ZERO_TRAP_EN
                    dz_n    = 1'b0;
`endif
                end
`ifdef DIV8B_ZERO_TRAP_EN
                if (dreg == 4'd0) begin
                    quot_n  = 8'hFF;
                    rem_n   = shreg[3:0];
                    dz_n    = 1'b1;
                    done_n  = 1'b1;
                    cnt_n   = 3'd0;
                    state_n = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= 8'd0;
            dreg   <= 4'd0;
            r      <= 4'd0;
            cnt    <= 3'd0;
            quot   <= 8'd0;
            rem    <= 4'd0;
            done_r <= 1'b0;
`ifdef DIV8B_ZERO_TRAP_EN
            dz     <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            dreg   <= dreg_n;
            r      <= r_n;
            cnt    <= cnt_n;
            quot   <= quot_n;
            rem    <= rem_n;
            done_r <= done_n;
`ifdef DIV8B_ZERO_TRAP_EN
            dz     <= dz_n;
`endif
        end
    end

    assign bus.quotient  = quot;
    assign bus.remainder = rem;
    assign bus.busy      = (state == CALC);
    assign bus.done      = done_r;
`ifdef DIV8B_ZERO_TRAP_EN
    assign bus.div_zero  = dz;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_div8b.sv
// Scoreboard bench for div8b: stimulus pushes expected results, a negedge monitor pops
// and compares them whenever done is seen, including the cycle the result arrived.
module tb_div8b;
    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         at;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   nChecks;
    int   nFails;
    int   doneCount;
    int   nPushed;
    int   busyCnt;
    int   zeroLat;
    logic zeroFlag;
    exp_t sb[$];
    exp_t e;

    div8b_if bus();

    div8b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called at a negedge with the DUT idle; accept edge is the next posedge.
    task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs,
                                 input logic [7:0] expQ, input logic [3:0] expR,
                                 input logic expDz, input int lat);
        exp_t x;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        x.q  = expQ;
        x.r  = expR;
        x.dz = expDz;
        x.at = cyc + 1 + lat;
        sb.push_back(x);
        nPushed++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int busyHigh);
        bit seen;
        busyHigh = bus.busy ? 1 : 0;
        seen = bus.done;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busyHigh++;
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("quotient", int'(bus.quotient), int'(e.q));
                checkOutput("remainder", int'(bus.remainder), int'(e.r));
                checkOutput("div_zero", int'(bus.div_zero), int'(e.dz));
                checkOutput("busy_at_done", int'(bus.busy), 0);
                checkOutput("done_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
`ifdef DIV8B_ZERO_TRAP_EN
        zeroLat  = 1;
        zeroFlag = 1'b1;
`else
        zeroLat  = 8;
        zeroFlag = 1'b0;
`endif
        cyc          = 0;
        nChecks      = 0;
        nFails       = 0;
        doneCount    = 0;
        nPushed      = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_quotient", int'(bus.quotient), 0);
        checkOutput("reset_remainder", int'(bus.remainder), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_div_zero", int'(bus.div_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 with busy duration
        applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 8);
        checkOutput("busy_after_accept", int'(bus.busy), 1);
        waitDone(busyCnt);
        checkOutput("busy_cycles", busyCnt, 8);
        @(negedge clk);
        checkOutput("done_pulse_low", int'(bus.done), 0);

        // 255 / 1, then 5 / 9 with results held meanwhile
        applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
        waitDone(busyCnt);
        repeat (2) @(negedge clk);
        applyStimulus(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
        checkOutput("held_quotient", int'(bus.quotient), 255);
        checkOutput("held_remainder", int'(bus.remainder), 0);
        repeat (5) @(negedge clk);
        checkOutput("held_quotient_late", int'(bus.quotient), 255);
        waitDone(busyCnt);
        @(negedge clk);

        // divide by zero
        applyStimulus(8'd200, 4'd0, 8'hFF, 4'd8, zeroFlag, zeroLat);
        waitDone(busyCnt);
        @(negedge clk);

        // 60 / 4 with input changes and start pulses while busy
        applyStimulus(8'd60, 4'd4, 8'd15, 4'd0, 1'b0, 8);
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        bus.start    = 1'b1;
        repeat (2) @(negedge clk);
        bus.start    = 1'b0;
        waitDone(busyCnt);
        repeat (12) @(negedge clk);
        checkOutput("single_done_count", doneCount, nPushed);

        // back-to-back: second start on the done cycle
        applyStimulus(8'd60, 4'd4, 8'd15, 4'd0, 1'b0, 8);
        waitDone(busyCnt);
        applyStimulus(8'd99, 4'd10, 8'd9, 4'd9, 1'b0, 8);
        checkOutput("b2b_busy", int'(bus.busy), 1);
        checkOutput("b2b_done_low", int'(bus.done), 0);
        waitDone(busyCnt);
        @(negedge clk);

        // reset during step 4 of 100 / 7
        applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_quotient", int'(bus.quotient), 0);
        checkOutput("midrst_remainder", int'(bus.remainder), 0);
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        checkOutput("midrst_div_zero", int'(bus.div_zero), 0);
        sb.delete();
        nPushed--;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("aborted_no_done", doneCount, nPushed);
        applyStimulus(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 8);
        waitDone(busyCnt);
        repeat (3) @(negedge clk);

        checkOutput("total_done_count", doneCount, nPushed);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
